// File: rtl/i8088_bus_pkg.sv
// Shared types and widths for the 8088 pin-level bus slave peripherals.
package i8088_bus_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ARMED, READ, WRITE} periph_state_t;

  typedef logic [ADDR_W-1:0] addr_t;

  // Window compare on the bits above the window offset.
  function automatic logic in_window(input addr_t addr, input addr_t base, input int bits);
    return (addr >> bits) == (base >> bits);
  endfunction

endpackage

// File: rtl/i8088_byte_ram.sv
// Byte-wide RAM: synchronous write, registered read, contents never reset.
module i8088_byte_ram
  import i8088_bus_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  output logic [DATA_W-1:0]    o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/i8088_mem_io_peripheral.sv
// 8088 bus-slave peripheral: address window claim, byte RAM over a tristate Data bus.
// Define I8088_PERIPH_WAIT_EN to insert WAIT_STATES READY-low cycles on every read.
module i8088_mem_io_peripheral
  import i8088_bus_pkg::*;
#(
  parameter addr_t BASE_ADDR   = 20'h00000,
  parameter int    ADDR_BITS   = 10,
  parameter logic  IS_IO       = 1'b0,
  parameter int    WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALE,
  input  logic              IOM,
  input  logic              RD,
  input  logic              WR,
  input  addr_t             ADDRESS,
  inout  wire  [DATA_W-1:0] Data,
  output logic              READY,
  output logic              sel,
  output logic              bus_err,
  output periph_state_t     o_state
);

  periph_state_t          r_state;
  logic [ADDR_BITS-1:0]   r_offset;
  logic [DATA_W-1:0]      r_wdata;
  logic                   r_sel;
  logic                   r_err;
  logic                   r_oe;
  logic                   w_hit;
  logic                   w_ram_re;
  logic                   w_ram_we;
  logic [DATA_W-1:0]      w_rdata;

  assign w_hit = in_window(ADDRESS, BASE_ADDR, ADDR_BITS) && (IOM == IS_IO);

  // The RAM read is launched on the ARMED->READ edge so rdata is ready when oe rises.
  assign w_ram_re = ((r_state == ARMED) && !ALE && !RD && WR) || (r_state == READ);
  assign w_ram_we = (r_state == WRITE) && !ALE && WR;

`ifdef I8088_PERIPH_WAIT_EN
  localparam int WAIT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  logic [WAIT_W-1:0] r_wait;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= IDLE;
      r_offset <= '0;
      r_wdata  <= '0;
      r_sel    <= 1'b0;
      r_err    <= 1'b0;
      r_oe     <= 1'b0;
`ifdef I8088_PERIPH_WAIT_EN
      r_wait   <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      if (!WR) r_wdata <= Data;
      if (ALE) begin
        // A new address phase abandons whatever cycle was in flight.
        r_err    <= (r_state == READ) || (r_state == WRITE);
        r_oe     <= 1'b0;
        r_offset <= ADDRESS[ADDR_BITS-1:0];
        r_sel    <= w_hit;
        r_state  <= w_hit ? ARMED : IDLE;
`ifdef I8088_PERIPH_WAIT_EN
        r_wait   <= '0;
`endif
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          ARMED: begin
            if (!RD && !WR) begin
              r_state <= IDLE;
              r_sel   <= 1'b0;
              r_err   <= 1'b1;
            end else if (!RD) begin
              r_state <= READ;
`ifdef I8088_PERIPH_WAIT_EN
              r_wait  <= WAIT_W'(WAIT_STATES);
`endif
            end else if (!WR) begin
              r_state <= WRITE;
            end
          end
          READ: begin
            if (!RD && !WR) begin
              r_state <= IDLE;
              r_sel   <= 1'b0;
              r_oe    <= 1'b0;
              r_err   <= 1'b1;
            end else if (RD) begin
              r_state <= IDLE;
              r_sel   <= 1'b0;
              r_oe    <= 1'b0;
`ifdef I8088_PERIPH_WAIT_EN
            end else if (r_wait != '0) begin
              r_wait  <= r_wait - 1'b1;
`endif
            end else begin
              r_oe    <= 1'b1;
            end
          end
          WRITE: begin
            if (!RD && !WR) begin
              r_state <= IDLE;
              r_sel   <= 1'b0;
              r_err   <= 1'b1;
            end else if (WR) begin
              r_state <= IDLE;
              r_sel   <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // READY low asks the CPU to stretch the cycle; the byte is only presented after it returns high.
`ifdef I8088_PERIPH_WAIT_EN
  assign READY = !((r_state == READ) && (r_wait != '0));
`else
  assign READY = 1'b1;
`endif

  i8088_byte_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (r_offset),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign Data    = r_oe ? w_rdata : {DATA_W{1'bz}};
  assign sel     = r_sel;
  assign bus_err = r_err;
  assign o_state = r_state;

endmodule
